// File: rtl/sparce_sasa_table.sv
// sparce_sasa_table
// Table of {preceding PC, skip metadata} entries written via a three-word
// configuration window (PC, META, CLEAR), with a zero-latency PC lookup.
// The PC write stages a pending PC. The META write then commits the entry,
// either in place over a valid entry with the same PC or at a round-robin
// victim slot.
// Optional feature: define SPARCE_SASA_STATS_EN to build the saturating
// lookup-hit counter behind hit_count (otherwise hit_count is tied to 0).
module sparce_sasa_table #(
  parameter int unsigned SASA_ENTRIES = 16,
  parameter logic [31:0] SASA_ADDR    = 32'h0000_1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] pc,
  output logic        valid,
  output logic [31:0] preceding_pc,
  output logic [15:0] insts_to_skip,
  output logic        condition,
  output logic [4:0]  sasa_rs1,
  output logic [4:0]  sasa_rs2,
  output logic [31:0] hit_count
);

  localparam int unsigned IDX_W      = $clog2(SASA_ENTRIES);
  localparam logic [31:0] ADDR_PC    = SASA_ADDR;
  localparam logic [31:0] ADDR_META  = SASA_ADDR + 32'd4;
  localparam logic [31:0] ADDR_CLEAR = SASA_ADDR + 32'd8;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_META = 1'b1
  } wr_state_e;

  // Lowest set bit wins: scan from the top so lower indices overwrite.
  function automatic logic [IDX_W-1:0] first_set(input logic [SASA_ENTRIES-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
    return idx;
  endfunction

  wr_state_e                state_r;
  wr_state_e                state_s;
  logic [31:0]              pend_pc_r;
  logic [IDX_W-1:0]         ptr_r;
  logic [SASA_ENTRIES-1:0]  valid_r;
  logic [31:0]              pc_tab_r [SASA_ENTRIES];
  logic [26:0]              meta_r   [SASA_ENTRIES];

  logic                     is_pc_wr_s;
  logic                     is_meta_wr_s;
  logic                     is_clear_wr_s;
  logic                     pend_load_s;
  logic                     commit_s;
  logic                     clear_s;

  logic [SASA_ENTRIES-1:0]  cmatch_vec_s;
  logic                     cmatch_any_s;
  logic [IDX_W-1:0]         commit_idx_s;
  logic [SASA_ENTRIES-1:0]  lmatch_vec_s;
  logic                     lmatch_any_s;
  logic [IDX_W-1:0]         lmatch_idx_s;

  // META bits [31:27] carry no information and are intentionally dropped.
  logic                     unused_meta_hi_s;
  assign unused_meta_hi_s = ^wr_data[31:27];

  assign is_pc_wr_s    = wr_en && (wr_addr == ADDR_PC);
  assign is_meta_wr_s  = wr_en && (wr_addr == ADDR_META);
  assign is_clear_wr_s = wr_en && (wr_addr == ADDR_CLEAR);

  // Per-entry compare of the pending PC (commit target) and the lookup PC.
  always_comb begin
    cmatch_vec_s = {SASA_ENTRIES{1'b0}};
    lmatch_vec_s = {SASA_ENTRIES{1'b0}};
    for (int i = 0; i < SASA_ENTRIES; i++) begin
      cmatch_vec_s[i] = valid_r[i] && (pc_tab_r[i] == pend_pc_r);
      lmatch_vec_s[i] = valid_r[i] && (pc_tab_r[i] == pc);
    end
  end

  assign cmatch_any_s = |cmatch_vec_s;
  assign commit_idx_s = cmatch_any_s ? first_set(cmatch_vec_s) : ptr_r;
  assign lmatch_any_s = |lmatch_vec_s;
  assign lmatch_idx_s = first_set(lmatch_vec_s);

  // Write FSM next-state and per-cycle table controls.
  always_comb begin
    state_s     = state_r;
    pend_load_s = 1'b0;
    commit_s    = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_pc_wr_s) begin
          pend_load_s = 1'b1;
          state_s     = WAIT_META;
        end else if (is_clear_wr_s) begin
          clear_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_META: begin
        if (is_pc_wr_s) begin
          pend_load_s = 1'b1;
          state_s     = WAIT_META;
        end else if (is_meta_wr_s) begin
          commit_s = 1'b1;
          state_s  = IDLE;
        end else if (is_clear_wr_s) begin
          clear_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = WAIT_META;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pending PC and round-robin victim pointer (advances only on new-PC commits).
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_pc_r <= 32'h0;
      ptr_r     <= {IDX_W{1'b0}};
    end else begin
      if (pend_load_s) begin
        pend_pc_r <= wr_data;
      end
      if (clear_s) begin
        ptr_r <= {IDX_W{1'b0}};
      end else if (commit_s && !cmatch_any_s) begin
        ptr_r <= ptr_r + IDX_W'(1);
      end
    end
  end

  // Table storage: clear drops valid bits, commit writes one entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_r <= {SASA_ENTRIES{1'b0}};
      for (int i = 0; i < SASA_ENTRIES; i++) begin
        pc_tab_r[i] <= 32'h0;
        meta_r[i]   <= 27'h0;
      end
    end else if (clear_s) begin
      valid_r <= {SASA_ENTRIES{1'b0}};
    end else if (commit_s) begin
      valid_r[commit_idx_s]  <= 1'b1;
      pc_tab_r[commit_idx_s] <= pend_pc_r;
      meta_r[commit_idx_s]   <= wr_data[26:0];
    end
  end

  // Zero-latency lookup outputs; all fields forced to 0 on a miss.
  always_comb begin
    valid         = 1'b0;
    preceding_pc  = 32'h0;
    insts_to_skip = 16'h0;
    condition     = 1'b0;
    sasa_rs1      = 5'h0;
    sasa_rs2      = 5'h0;
    if (lmatch_any_s) begin
      valid         = 1'b1;
      preceding_pc  = pc_tab_r[lmatch_idx_s];
      insts_to_skip = meta_r[lmatch_idx_s][26:11];
      condition     = meta_r[lmatch_idx_s][0];
      sasa_rs1      = meta_r[lmatch_idx_s][5:1];
      sasa_rs2      = meta_r[lmatch_idx_s][10:6];
    end else begin
      valid = 1'b0;
    end
  end

`ifdef SPARCE_SASA_STATS_EN
  logic [31:0] hit_count_r;

  // Saturating count of cycles on which the lookup hits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_r <= 32'h0;
    end else if (clear_s) begin
      hit_count_r <= 32'h0;
    end else if (lmatch_any_s && (hit_count_r != 32'hFFFF_FFFF)) begin
      hit_count_r <= hit_count_r + 32'd1;
    end
  end

  assign hit_count = hit_count_r;
`else
  assign hit_count = 32'h0;
`endif

endmodule

// File: tb/tb_sparce_sasa_table.sv
// Testbench for sparce_sasa_table: directed scenarios followed by random
// configuration traffic, checked against an entry-array reference model.
module tb_sparce_sasa_table;

  localparam int          N    = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pc;
  logic        valid;
  logic [31:0] preceding_pc;
  logic [15:0] insts_to_skip;
  logic        condition;
  logic [4:0]  sasa_rs1;
  logic [4:0]  sasa_rs2;
  logic [31:0] hit_count;

  sparce_sasa_table dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc(pc), .valid(valid), .preceding_pc(preceding_pc),
    .insts_to_skip(insts_to_skip), .condition(condition),
    .sasa_rs1(sasa_rs1), .sasa_rs2(sasa_rs2), .hit_count(hit_count)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  bit          m_valid [N];
  logic [31:0] m_pc    [N];
  logic [31:0] m_meta  [N];
  int          m_ptr;
  bit          m_wait;
  logic [31:0] m_pend;
  logic [31:0] m_hits = 32'h0;

  int n_pass   = 0;
  int n_checks = 0;

  function automatic int model_find(input logic [31:0] p);
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_pc[i] == p) return i;
    end
    return -1;
  endfunction

  // Model hit statistic, evaluated on the table contents seen before each edge.
  always @(posedge CLK) begin
    if (RST || (wr_en && wr_addr == BASE + 32'd8)) m_hits <= 32'h0;
    else if (model_find(pc) >= 0 && m_hits != 32'hFFFF_FFFF) m_hits <= m_hits + 32'd1;
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_ptr  = 0;
    m_wait = 1'b0;
    m_pend = 32'h0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    int idx;
    if (a == BASE) begin
      m_pend = d;
      m_wait = 1'b1;
    end else if (a == BASE + 32'd4) begin
      if (m_wait) begin
        idx = model_find(m_pend);
        if (idx < 0) begin
          idx   = m_ptr;
          m_ptr = (m_ptr + 1) % N;
        end
        m_valid[idx] = 1'b1;
        m_pc[idx]    = m_pend;
        m_meta[idx]  = d;
        m_wait       = 1'b0;
      end
    end else if (a == BASE + 32'd8) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_ptr  = 0;
      m_wait = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge CLK);
    #1;
    wr_en = 1'b0;
    model_write(a, d);
  endtask

  task automatic commit(input logic [31:0] p, input logic [31:0] meta);
    wr(BASE, p);
    wr(BASE + 32'd4, meta);
  endtask

  task automatic do_rst();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  task automatic look(input logic [31:0] p, input string tag);
    int          idx;
    logic [31:0] e;
    logic [31:0] exp_hc;
    @(negedge CLK);
    pc = p;
    #1;
    idx = model_find(p);
    e   = (idx >= 0) ? m_meta[idx] : 32'h0;
`ifdef SPARCE_SASA_STATS_EN
    exp_hc = m_hits;
`else
    exp_hc = 32'h0;
`endif
    chk({tag, "_valid"}, {31'h0, valid}, (idx >= 0) ? 32'd1 : 32'd0);
    chk({tag, "_ppc"},   preceding_pc, (idx >= 0) ? m_pc[idx] : 32'h0);
    chk({tag, "_skip"},  {16'h0, insts_to_skip}, {16'h0, e[26:11]});
    chk({tag, "_cond"},  {31'h0, condition}, {31'h0, e[0]});
    chk({tag, "_rs1"},   {27'h0, sasa_rs1}, {27'h0, e[5:1]});
    chk({tag, "_rs2"},   {27'h0, sasa_rs2}, {27'h0, e[10:6]});
    chk({tag, "_hits"},  hit_count, exp_hc);
  endtask

  initial begin
    logic [31:0] rp;
    int          r;

    RST     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 32'h0;
    wr_data = 32'h0;
    pc      = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();

    // Reset state: everything reads 0
    look(32'h200, "rst_a");
    look(32'h0,   "rst_b");
    chk("rst_valid_lit", {31'h0, valid}, 32'd0);

    // Basic commit and lookup
    commit(32'h200, 32'h0000_1843);
    look(32'h200, "basic");
    chk("basic_valid_lit", {31'h0, valid}, 32'd1);
    chk("basic_skip_lit",  {16'h0, insts_to_skip}, 32'd3);
    chk("basic_cond_lit",  {31'h0, condition}, 32'd1);
    chk("basic_rs1_lit",   {27'h0, sasa_rs1}, 32'd1);
    chk("basic_rs2_lit",   {27'h0, sasa_rs2}, 32'd1);
    chk("basic_ppc_lit",   preceding_pc, 32'h200);

    // Wrap: N+1 distinct PCs evict the oldest
    wr(BASE + 32'd8, 32'h0);
    for (int i = 0; i <= N; i++) commit(32'h100 + 32'(4 * i), 32'(i) << 11);
    look(32'h100, "wrap_old");
    chk("wrap_old_lit", {31'h0, valid}, 32'd0);
    look(32'h100 + 32'(4 * N), "wrap_new");
    chk("wrap_new_skip_lit", {16'h0, insts_to_skip}, 32'(N));
    look(32'h104, "wrap_keep");

    // Re-commit updates in place without moving the pointer
    wr(BASE + 32'd8, 32'h0);
    commit(32'h200, 32'h0000_1843);
    commit(32'h200, 32'd5 << 11);
    look(32'h200, "recommit");
    chk("recommit_skip_lit", {16'h0, insts_to_skip}, 32'd5);
    for (int i = 1; i < N; i++) commit(32'h400 + 32'(4 * i), 32'h0000_0001);
    commit(32'h300, 32'h0000_0002);
    look(32'h200, "ptr_evict");
    chk("ptr_evict_lit", {31'h0, valid}, 32'd0);
    look(32'h404, "ptr_keep");
    chk("ptr_keep_lit", {31'h0, valid}, 32'd1);

    // META in IDLE ignored; reset discards pending PC
    wr(BASE + 32'd8, 32'h0);
    wr(BASE + 32'd4, 32'h0000_1843);
    look(32'h200, "meta_idle");
    chk("meta_idle_lit", {31'h0, valid}, 32'd0);
    wr(BASE, 32'h200);
    do_rst();
    wr(BASE + 32'd4, 32'h0000_1843);
    look(32'h200, "rst_pend");
    chk("rst_pend_lit", {31'h0, valid}, 32'd0);

    // CLEAR while hitting: visible only the following cycle
    commit(32'h200, 32'h0000_1843);
    look(32'h200, "pre_clear");
    @(negedge CLK);
    wr_en   = 1'b1;
    wr_addr = BASE + 32'd8;
    wr_data = 32'h0;
    #1;
    chk("clear_same_cycle", {31'h0, valid}, 32'd1);
    @(posedge CLK);
    #1;
    wr_en = 1'b0;
    model_write(BASE + 32'd8, 32'h0);
    chk("clear_next_cycle", {31'h0, valid}, 32'd0);
    chk("clear_hits", hit_count, 32'd0);

    // Hold a hit for exactly 10 cycles
    look(32'h0, "pre_hold");
    commit(32'h200, 32'h0000_1843);
    @(negedge CLK);
    pc = 32'h200;
    repeat (10) @(posedge CLK);
    #1;
`ifdef SPARCE_SASA_STATS_EN
    chk("hold_hits", hit_count, 32'd10);
`else
    chk("hold_hits", hit_count, 32'd0);
`endif
    look(32'h0, "post_hold");

    // Random configuration traffic
    for (int k = 0; k < 300; k++) begin
      r  = int'($urandom_range(0, 19));
      rp = 32'h100 + 32'($urandom_range(0, 23)) * 32'd4;
      case (r)
        0, 1, 2, 3, 4, 5: wr(BASE, rp);
        6, 7, 8, 9:       wr(BASE + 32'd4, $urandom());
        10:               wr(BASE + 32'd8, $urandom());
        11:               wr(BASE + 32'd1 + 32'($urandom_range(0, 2)), $urandom());
        12:               wr(BASE + 32'd12 + 32'($urandom_range(0, 4)) * 32'd4, $urandom());
        13:               if ($urandom_range(0, 3) == 0) do_rst(); else look(rp, "rnd");
        default:          look(rp, "rnd");
      endcase
    end
    look(32'h100, "final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sparce_sasa_table.md
SPARCE_SASA_TABLE -- requirements
Module: sparce_sasa_table

Interface
REQ-001 Parameter SASA_ENTRIES, default 16, number of table entries; SHALL be a power of 2 and at least 2.
REQ-002 Parameter SASA_ADDR, default 32'h0000_1000, base of the config window: +0 PC word, +4 META word, +8 CLEAR.
REQ-003 Port CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port RST  input  1  reset, synchronous and active-high.
REQ-005 Port wr_en  input  1  config-write strobe, one write per asserted cycle.
REQ-006 Port wr_addr  input  32  config-write byte address.
REQ-007 Port wr_data  input  32  config-write data.
REQ-008 Port pc  input  32  PC of the instruction being looked up.
REQ-009 Port valid  output  1  pc matches a valid entry; drives the PSRU valid input.
REQ-010 Port preceding_pc  output  32  matched entry PC.
REQ-011 Port insts_to_skip  output  16  matched entry skip count.
REQ-012 Port condition  output  1  1 = OR, 0 = AND.
REQ-013 Port sasa_rs1, sasa_rs2  output  5 each  register indices whose sparsity the PSRU consumes.
REQ-014 Port hit_count  output  32  lookup-hit statistic (see Configuration).

Function
REQ-015 META word layout SHALL be: [0] condition, [5:1] rs1, [10:6] rs2, [26:11] insts_to_skip; bits [31:27] are ignored.
REQ-016 Write FSM SHALL have states IDLE and WAIT_META.
REQ-017 A write to +0 SHALL capture wr_data as the pending PC and enter WAIT_META, from either state; in WAIT_META the new PC replaces the old one.
REQ-018 A write to +4 in WAIT_META SHALL commit {pending PC, META} to one entry, set that entry valid, and return to IDLE.
REQ-019 A write to +4 in IDLE SHALL be ignored.
REQ-020 Commit target SHALL be the existing valid entry whose PC equals the pending PC, if any; otherwise the entry at the round-robin pointer.
REQ-021 The pointer SHALL advance only on a non-matching commit and SHALL wrap from SASA_ENTRIES-1 to 0, overwriting the oldest entry.
REQ-022 A write to +8 in any state SHALL invalidate all entries, zero the pointer and enter IDLE.
REQ-023 Writes to any other address, including unaligned offsets, SHALL be ignored.
REQ-024 Lookup SHALL be combinational from registered table state, with zero-cycle latency.
REQ-025 A commit or clear SHALL become visible to lookup on the cycle after the write.
REQ-026 On multiple matches the lowest index SHALL win; REQ-020 prevents this in normal use.
REQ-027 With no match, valid SHALL be 0 and all other entry outputs SHALL be 0.

Reset
REQ-028 RST SHALL invalidate all entries, zero the pointer, select IDLE, clear the pending PC and zero hit_count.
REQ-029 After reset, every output SHALL be 0 until the first commit.
REQ-030 RST asserted during WAIT_META SHALL discard the pending PC, so a following META write is ignored.

Configuration
REQ-031 With macro SPARCE_SASA_STATS_EN defined, hit_count SHALL increment on every cycle with valid=1, saturate at 32'hFFFF_FFFF, and be zeroed by RST or CLEAR.
REQ-032 Without SPARCE_SASA_STATS_EN, hit_count SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-033 Write +0=0x200, then +4=0x0000_1843 (cond=1, rs1=1, rs2=1, skip=3) -> next cycle, pc=0x200 gives valid=1, insts_to_skip=3, condition=1, sasa_rs1=1, sasa_rs2=1.
REQ-034 Commit SASA_ENTRIES+1 distinct PCs 0x100, 0x104, ... -> 0x100 misses and the last PC sits in entry 0.
REQ-035 Re-commit PC 0x200 with skip=5 -> lookup gives 5 and the pointer is unchanged.
REQ-036 META write in IDLE, and RST between the PC and META writes -> pc=0x200 misses.
REQ-037 Write CLEAR while pc=0x200 is hitting -> valid stays 1 that cycle, is 0 the next cycle, and hit_count reads 0 with stats on.
REQ-038 With SPARCE_SASA_STATS_EN, hold pc on a hit entry for 10 cycles -> hit_count=10; without the macro -> hit_count=0.
